mshr_miss_dispatcher: RTL



---
 rtl/mshr_miss_dispatcher.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mshr_miss_dispatcher.sv
// Pulls pending misses from the MSHR and issues them to memory.
// Matches memory responses back to entries, completes them to the CPU, and retires them.
module mshr_miss_dispatcher #(
    parameter int addr_bits     = 20,
    parameter int data_bits     = 90,
    parameter int mshr_tag_bits = 3,
    parameter int cpu_id_bits   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    output logic                     read_next,
    input  logic                     rn_valid,
    input  logic [addr_bits-1:0]     rn_addr,
    input  logic [data_bits-1:0]     rn_data,
    input  logic                     rn_rw,
    input  logic                     rn_dirty,
    input  logic [cpu_id_bits-1:0]   rn_cpu_id,
    input  logic [mshr_tag_bits-1:0] rn_mshr_id,
    output logic                     get,
    output logic [mshr_tag_bits-1:0] get_tag,
    input  logic                     get_valid,
    input  logic [addr_bits-1:0]     get_addr,
    input  logic [data_bits-1:0]     get_data,
    input  logic                     get_rw,
    input  logic                     get_dirty,
    input  logic [cpu_id_bits-1:0]   get_cpu_id,
    output logic                     del,
    output logic [mshr_tag_bits-1:0] del_tag,
    input  logic                     empty,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic [addr_bits-1:0]     mem_req_addr,
    output logic [data_bits-1:0]     mem_req_data,
    output logic                     mem_req_rw,
    output logic                     mem_req_dirty,
    output logic [mshr_tag_bits-1:0] mem_req_tag,
    input  logic                     mem_resp_valid,
    output logic                     mem_resp_ready,
    input  logic [mshr_tag_bits-1:0] mem_resp_tag,
    input  logic [data_bits-1:0]     mem_resp_data,
    output logic                     cpu_resp_valid,
    input  logic                     cpu_resp_ready,
    output logic [cpu_id_bits-1:0]   cpu_resp_cpu_id,
    output logic [addr_bits-1:0]     cpu_resp_addr,
    output logic [data_bits-1:0]     cpu_resp_data,
    output logic                     cpu_resp_rw,
    output logic [mshr_tag_bits:0]   outstanding,
    output logic                     lookup_err,
    output logic                     idle
);

    typedef enum logic {I_IDLE, I_REQ} issue_state_e;
    typedef enum logic [1:0] {R_IDLE, R_LOOKUP, R_SEND} resp_state_e;

    localparam logic [mshr_tag_bits:0] CntOne = {{mshr_tag_bits{1'b0}}, 1'b1};
    localparam logic [mshr_tag_bits:0] CntMax = {1'b1, {mshr_tag_bits{1'b0}}};

    issue_state_e r_issueState, w_issueNext;
    resp_state_e  r_respState,  w_respNext;

    logic [addr_bits-1:0]     r_reqAddr;
    logic [data_bits-1:0]     r_reqData;
    logic                     r_reqRw;
    logic                     r_reqDirty;
    logic [mshr_tag_bits-1:0] r_reqTag;
    logic [mshr_tag_bits-1:0] r_respTag;
    logic [data_bits-1:0]     r_memData;
    logic [cpu_id_bits-1:0]   r_cpuId;
    logic [addr_bits-1:0]     r_cpuAddr;
    logic [data_bits-1:0]     r_cpuData;
    logic                     r_cpuRw;
    logic [mshr_tag_bits:0]   r_outstanding;
    logic                     r_lookupErr;
    logic                     w_issueFire;
    logic                     w_respCapture;
    logic                     w_unusedDirty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_issueState <= I_IDLE;
            r_respState  <= R_IDLE;
        end else if (enable) begin
            r_issueState <= w_issueNext;
            r_respState  <= w_respNext;
        end
    end

    always_comb begin
        w_issueNext = r_issueState;
        case (r_issueState)
            I_IDLE:  if (rn_valid) w_issueNext = I_REQ;
            I_REQ:   if (mem_req_ready) w_issueNext = I_IDLE;
            default: w_issueNext = I_IDLE;
        endcase
        w_respNext = r_respState;
        case (r_respState)
            R_IDLE:   if (mem_resp_valid) w_respNext = R_LOOKUP;
            R_LOOKUP: w_respNext = get_valid ? R_SEND : R_IDLE;
            R_SEND:   if (cpu_resp_ready) w_respNext = R_IDLE;
            default:  w_respNext = R_IDLE;
        endcase
    end

    // Pulses are masked during reset so nothing is popped or retired while the block restarts.
    always_comb begin
        read_next      = enable && !reset && (r_issueState == I_IDLE) && rn_valid;
        mem_req_valid  = (r_issueState == I_REQ);
        mem_resp_ready = enable && (r_respState == R_IDLE);
        get            = enable && !reset && (r_respState == R_LOOKUP);
        cpu_resp_valid = (r_respState == R_SEND);
        del            = enable && !reset && cpu_resp_valid && cpu_resp_ready;
    end

    assign w_issueFire   = enable && mem_req_valid && mem_req_ready;
    assign w_respCapture = mem_resp_ready && mem_resp_valid;
    assign w_unusedDirty = get_dirty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_reqAddr  <= '0;
            r_reqData  <= '0;
            r_reqRw    <= 1'b0;
            r_reqDirty <= 1'b0;
            r_reqTag   <= '0;
        end else if (read_next) begin
            r_reqAddr  <= rn_addr;
            r_reqData  <= rn_data;
            r_reqRw    <= rn_rw;
            r_reqDirty <= rn_dirty;
            r_reqTag   <= rn_mshr_id;
        end
    end

    // Writes complete with the entry's own data, reads with what memory returned.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_respTag   <= '0;
            r_memData   <= '0;
            r_cpuId     <= '0;
            r_cpuAddr   <= '0;
            r_cpuData   <= '0;
            r_cpuRw     <= 1'b0;
            r_lookupErr <= 1'b0;
        end else begin
            if (w_respCapture) begin
                r_respTag <= mem_resp_tag;
                r_memData <= mem_resp_data;
            end
            if (get && get_valid) begin
                r_cpuId   <= get_cpu_id;
                r_cpuAddr <= get_addr;
                r_cpuData <= get_rw ? get_data : r_memData;
                r_cpuRw   <= get_rw;
            end
            if (get && !get_valid) r_lookupErr <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_outstanding <= '0;
        end else begin
            case ({w_issueFire, del})
                2'b10:   if (r_outstanding != CntMax) r_outstanding <= r_outstanding + CntOne;
                2'b01:   if (r_outstanding != '0) r_outstanding <= r_outstanding - CntOne;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign mem_req_addr    = r_reqAddr;
    assign mem_req_data    = r_reqData;
    assign mem_req_rw      = r_reqRw;
    assign mem_req_dirty   = r_reqDirty;
    assign mem_req_tag     = r_reqTag;
    assign get_tag         = r_respTag;
    assign del_tag         = r_respTag;
    assign cpu_resp_cpu_id = r_cpuId;
    assign cpu_resp_addr   = r_cpuAddr;
    assign cpu_resp_data   = r_cpuData;
    assign cpu_resp_rw     = r_cpuRw;
    assign outstanding     = r_outstanding;
    assign lookup_err      = r_lookupErr;
    assign idle            = (r_outstanding == '0) && empty &&
                             (r_issueState == I_IDLE) && (r_respState == R_IDLE);

endmodule
